// File: rtl/pic_8259_pkg.sv
// Shared encodings for the 8259A bus master: host opcodes, FSM states, ICW1 bit positions
// and the opcode-to-bus mapping helpers.
package pic_8259_pkg;

  typedef enum logic [2:0] {
    OP_ICW1 = 3'd0,
    OP_ICW2 = 3'd1,
    OP_ICW3 = 3'd2,
    OP_ICW4 = 3'd3,
    OP_OCW1 = 3'd4,
    OP_OCW2 = 3'd5,
    OP_OCW3 = 3'd6,
    OP_READ = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    INIT_UNINIT   = 3'd0,
    INIT_EXP_ICW2 = 3'd1,
    INIT_EXP_ICW3 = 3'd2,
    INIT_EXP_ICW4 = 3'd3,
    INIT_READY    = 3'd4
  } init_state_e;

  typedef enum logic [2:0] {
    BUS_IDLE    = 3'd0,
    BUS_SETUP   = 3'd1,
    BUS_STROBE  = 3'd2,
    BUS_HOLD    = 3'd3,
    BUS_RECOVER = 3'd4
  } bus_state_e;

  localparam int ICW1_IC4_BIT  = 0;
  localparam int ICW1_SNGL_BIT = 1;

  // ICW1 is recognised by the PIC through D4=1 with A0=0; OCW2/OCW3 share A0=0 and
  // are told apart by D4:D3 = 00 / 01.
  function automatic logic [7:0] map_data(input cmd_op_e op, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    case (op)
      OP_ICW1: r = d | 8'h10;
      OP_OCW2: r = d & 8'hE7;
      OP_OCW3: r = (d & 8'hE7) | 8'h08;
      OP_READ: r = 8'h00;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic map_a0(input cmd_op_e op, input logic [7:0] d);
    logic r;
    r = 1'b0;
    case (op)
      OP_ICW2, OP_ICW3, OP_ICW4, OP_OCW1: r = 1'b1;
      OP_READ:                            r = d[0];
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_8259_if.sv
// Host command/response channel plus the PIC-side pins, bundled for the bus master.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
// the host holds op/data stable while cmd_valid is high. rsp_valid is a single-cycle pulse
// with no back-pressure, and rsp_error/rsp_data are meaningful only while it is high.
interface pic_8259_if;
  import pic_8259_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        chip_select_n;
  logic        write_enable_n;
  logic        read_enable_n;
  logic        address;
  logic [7:0]  data_bus_out;
  logic        data_bus_oe;
  logic [7:0]  data_bus_in;
  logic        init_done;
  bus_state_e  dbg_bus_state;
  init_state_e dbg_init_state;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, data_bus_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output chip_select_n, write_enable_n, read_enable_n, address,
    output data_bus_out, data_bus_oe, init_done, dbg_bus_state, dbg_init_state
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, data_bus_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  chip_select_n, write_enable_n, read_enable_n, address,
    input  data_bus_out, data_bus_oe, init_done, dbg_bus_state, dbg_init_state
  );

endinterface

// File: rtl/pic_8259_bus_cycle.sv
// Timed CS#/WR#/RD# bus cycle generator: one down-counter shared by all phases, reloaded
// on entry to each phase; pins are decoded from the registered state.
module pic_8259_bus_cycle
  import pic_8259_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_is_read,
  input  logic       i_a0,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_din,
  output logic       o_idle,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_cs_n,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic       o_a0,
  output logic [7:0] o_dout,
  output logic       o_oe,
  output bus_state_e o_state
);

  localparam int MAX_SP = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_HR = (HOLD_CYCLES > RECOVER_CYCLES) ? HOLD_CYCLES : RECOVER_CYCLES;
  localparam int MAX_P  = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef logic [CW-1:0] cnt_t;

  bus_state_e r_state;
  bus_state_e w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_cnt_nxt;
  logic       r_a0;
  logic [7:0] r_wdata;
  logic       r_is_read;
  logic [7:0] r_rd_data;
  logic       w_load;
  logic       w_active;
  logic       w_rsp;

  assign w_load = (r_state == BUS_IDLE) && i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BUS_IDLE;
      r_cnt     <= '0;
      r_a0      <= 1'b0;
      r_wdata   <= 8'h00;
      r_is_read <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_a0      <= i_a0;
        r_wdata   <= i_is_read ? 8'h00 : i_wdata;
        r_is_read <= i_is_read;
      end
      // Sample at the end of the strobe, when the PIC has had the longest to drive.
      if ((r_state == BUS_STROBE) && (r_cnt == '0) && r_is_read) begin
        r_rd_data <= i_din;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - cnt_t'(1)) : '0;
    case (r_state)
      BUS_IDLE: begin
        if (i_start) begin
          w_state_nxt = BUS_SETUP;
          w_cnt_nxt   = cnt_t'(SETUP_CYCLES - 1);
        end
      end
      BUS_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = BUS_STROBE;
          w_cnt_nxt   = cnt_t'(STROBE_CYCLES - 1);
        end
      end
      BUS_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = BUS_HOLD;
          w_cnt_nxt   = cnt_t'(HOLD_CYCLES - 1);
        end
      end
      BUS_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = BUS_RECOVER;
          w_cnt_nxt   = cnt_t'(RECOVER_CYCLES - 1);
        end
      end
      BUS_RECOVER: begin
        if (r_cnt == '0) begin
          w_state_nxt = BUS_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = BUS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_active = (r_state == BUS_SETUP) || (r_state == BUS_STROBE) || (r_state == BUS_HOLD);
  assign w_rsp    = (r_state == BUS_RECOVER) && (r_cnt == cnt_t'(RECOVER_CYCLES - 1));

  assign o_idle      = (r_state == BUS_IDLE);
  assign o_rsp_valid = w_rsp;
  assign o_rsp_data  = (w_rsp && r_is_read) ? r_rd_data : 8'h00;
  assign o_cs_n      = ~w_active;
  assign o_wr_n      = ~((r_state == BUS_STROBE) && !r_is_read);
  assign o_rd_n      = ~((r_state == BUS_STROBE) && r_is_read);
  assign o_a0        = w_active & r_a0;
  assign o_oe        = w_active & ~r_is_read;
  assign o_dout      = (w_active && !r_is_read) ? r_wdata : 8'h00;
  assign o_state     = r_state;

endmodule

// File: rtl/pic_8259_bus_master.sv
// CPU-side 8259A initiator: tracks the ICW programming sequence, maps host opcodes onto
// A0/data, and either launches a bus cycle or answers immediately with an error.
module pic_8259_bus_master
  import pic_8259_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  pic_8259_if.master    bus
);

  cmd_op_e     w_op;
  init_state_e r_init;
  init_state_e w_init_nxt;
  init_state_e w_target;
  logic        r_sngl;
  logic        r_ic4;
  logic        r_rej;
  logic        w_legal;
  logic        w_idle;
  logic        w_accept;
  logic        w_start;
  logic        w_bus_rsp;
  logic [7:0]  w_bus_rsp_data;

  assign w_op     = cmd_op_e'(bus.cmd_op);
  assign w_accept = bus.cmd_valid & w_idle;
  assign w_start  = w_accept & w_legal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init <= INIT_UNINIT;
      r_sngl <= 1'b0;
      r_ic4  <= 1'b0;
      r_rej  <= 1'b0;
    end else begin
      r_init <= w_init_nxt;
      r_rej  <= w_accept & ~w_legal;
      if (w_accept && (w_op == OP_ICW1)) begin
        r_sngl <= bus.cmd_data[ICW1_SNGL_BIT];
        r_ic4  <= bus.cmd_data[ICW1_IC4_BIT];
      end
    end
  end

  // ICW1 always restarts the sequence; READ never disturbs it.
  always_comb begin
    w_legal    = 1'b0;
    w_target   = r_init;
    w_init_nxt = r_init;
    case (w_op)
      OP_ICW1: begin
        w_legal  = 1'b1;
        w_target = INIT_EXP_ICW2;
      end
      OP_ICW2: begin
        w_legal  = (r_init == INIT_EXP_ICW2);
        w_target = !r_sngl ? INIT_EXP_ICW3 : (r_ic4 ? INIT_EXP_ICW4 : INIT_READY);
      end
      OP_ICW3: begin
        w_legal  = (r_init == INIT_EXP_ICW3);
        w_target = r_ic4 ? INIT_EXP_ICW4 : INIT_READY;
      end
      OP_ICW4: begin
        w_legal  = (r_init == INIT_EXP_ICW4);
        w_target = INIT_READY;
      end
      OP_OCW1, OP_OCW2, OP_OCW3: begin
        w_legal  = (r_init == INIT_READY);
      end
      OP_READ: begin
        w_legal  = 1'b1;
      end
      default: begin
        w_legal  = 1'b0;
      end
    endcase
    if (w_accept && w_legal) begin
      w_init_nxt = w_target;
    end
  end

  pic_8259_bus_cycle #(
    .SETUP_CYCLES   (SETUP_CYCLES),
    .STROBE_CYCLES  (STROBE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .RECOVER_CYCLES (RECOVER_CYCLES)
  ) u_bus_cycle (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_start     (w_start),
    .i_is_read   (w_op == OP_READ),
    .i_a0        (map_a0(w_op, bus.cmd_data)),
    .i_wdata     (map_data(w_op, bus.cmd_data)),
    .i_din       (bus.data_bus_in),
    .o_idle      (w_idle),
    .o_rsp_valid (w_bus_rsp),
    .o_rsp_data  (w_bus_rsp_data),
    .o_cs_n      (bus.chip_select_n),
    .o_wr_n      (bus.write_enable_n),
    .o_rd_n      (bus.read_enable_n),
    .o_a0        (bus.address),
    .o_dout      (bus.data_bus_out),
    .o_oe        (bus.data_bus_oe),
    .o_state     (bus.dbg_bus_state)
  );

  assign bus.cmd_ready      = w_idle;
  assign bus.rsp_valid      = w_bus_rsp | r_rej;
  assign bus.rsp_error      = r_rej;
  assign bus.rsp_data       = w_bus_rsp_data;
  assign bus.init_done      = (r_init == INIT_READY);
  assign bus.dbg_init_state = r_init;

endmodule

// File: tb/tb_pic_8259_bus_master.sv
// Directed bench for pic_8259_bus_master: init sequences, rejections, OCW mapping,
// reads from a simple PIC model, strobe timing and reset abort.
module tb_pic_8259_bus_master;
  import pic_8259_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] pic_val = 8'h00;

  pic_8259_if bus();

  pic_8259_bus_master dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // PIC model: drives its value only while RD# is low, garbage otherwise.
  assign bus.data_bus_in = bus.read_enable_n ? 8'hEE : pic_val;

  int         o_cs, o_wr, o_rd, o_lat;
  logic       o_got, o_err, o_a0, o_oe, o_stable;
  logic [7:0] o_dout, o_rdata;

  int gap_run = 0;
  int min_gap = 1000;
  bit seen_low = 1'b0;

  always @(negedge clk) begin
    if (bus.chip_select_n) gap_run++;
    else begin
      if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
      gap_run  = 0;
      seen_low = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch the bus until its response (bounded).
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d);
    int n;
    bit first;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    o_cs = 0; o_wr = 0; o_rd = 0; o_lat = 0;
    o_got = 1'b0; o_err = 1'b0; o_a0 = 1'b0; o_oe = 1'b0; o_stable = 1'b1;
    o_dout = 8'h00; o_rdata = 8'h00;
    first = 1'b1;
    for (int i = 0; i < 20; i++) begin
      o_lat++;
      if (!bus.chip_select_n) begin
        o_cs++;
        if (first) begin
          o_a0 = bus.address; o_dout = bus.data_bus_out; o_oe = bus.data_bus_oe;
          first = 1'b0;
        end else if (bus.address !== o_a0 || bus.data_bus_out !== o_dout || bus.data_bus_oe !== o_oe) begin
          o_stable = 1'b0;
        end
      end
      if (!bus.write_enable_n) o_wr++;
      if (!bus.read_enable_n) o_rd++;
      if (bus.rsp_valid) begin
        o_got = 1'b1; o_err = bus.rsp_error; o_rdata = bus.rsp_data;
        break;
      end
      @(negedge clk);
    end
    check("rsp_seen", o_got, 1);
  endtask

  initial begin
    int rsp_cnt, cs_cnt;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_cs_n", bus.chip_select_n, 1);
    check("rst_wr_n", bus.write_enable_n, 1);
    check("rst_rd_n", bus.read_enable_n, 1);
    check("rst_a0", bus.address, 0);
    check("rst_dout", bus.data_bus_out, 0);
    check("rst_oe", bus.data_bus_oe, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_init_done", bus.init_done, 0);
    rst_n = 1'b1;

    // OCW1 before init: rejected without bus activity.
    do_cmd(3'd4, 8'hFF);
    check("ocw1_pre_err", o_err, 1);
    check("ocw1_pre_cs", o_cs, 0);
    check("ocw1_pre_lat", o_lat, 1);

    // Full init: SNGL=0, IC4=1.
    do_cmd(3'd0, 8'h11);
    check("icw1_err", o_err, 0);
    check("icw1_cs", o_cs, 4);
    check("icw1_wr", o_wr, 2);
    check("icw1_rd", o_rd, 0);
    check("icw1_lat", o_lat, 5);
    check("icw1_a0", o_a0, 0);
    check("icw1_dout", o_dout, 8'h11);
    check("icw1_oe", o_oe, 1);
    check("icw1_stable", o_stable, 1);
    check("icw1_rdata", o_rdata, 0);
    check("icw1_init", bus.init_done, 0);
    do_cmd(3'd1, 8'h20);
    check("icw2_a0", o_a0, 1);
    check("icw2_dout", o_dout, 8'h20);
    check("icw2_init", bus.init_done, 0);
    do_cmd(3'd2, 8'h04);
    check("icw3_err", o_err, 0);
    check("icw3_a0", o_a0, 1);
    check("icw3_dout", o_dout, 8'h04);
    check("icw3_init", bus.init_done, 0);
    do_cmd(3'd3, 8'h01);
    check("icw4_a0", o_a0, 1);
    check("icw4_dout", o_dout, 8'h01);
    check("icw4_init", bus.init_done, 1);

    // OCWs after init.
    do_cmd(3'd4, 8'hFF);
    check("ocw1_err", o_err, 0);
    check("ocw1_wr", o_wr, 2);
    check("ocw1_a0", o_a0, 1);
    check("ocw1_dout", o_dout, 8'hFF);
    do_cmd(3'd6, 8'h02);
    check("ocw3_a0", o_a0, 0);
    check("ocw3_dout", o_dout, 8'h0A);
    do_cmd(3'd5, 8'h3F);
    check("ocw2_a0", o_a0, 0);
    check("ocw2_dout", o_dout, 8'h27);

    // Reads from the PIC model.
    pic_val = 8'h5A;
    do_cmd(3'd7, 8'h00);
    check("rd0_err", o_err, 0);
    check("rd0_rd", o_rd, 2);
    check("rd0_wr", o_wr, 0);
    check("rd0_a0", o_a0, 0);
    check("rd0_oe", o_oe, 0);
    check("rd0_data", o_rdata, 8'h5A);
    pic_val = 8'hC3;
    do_cmd(3'd7, 8'h01);
    check("rd1_a0", o_a0, 1);
    check("rd1_data", o_rdata, 8'hC3);

    // Short init: SNGL=1, IC4=0; ICW1 restarts from READY.
    do_cmd(3'd0, 8'h0A);
    check("sicw1_dout", o_dout, 8'h1A);
    check("sicw1_init", bus.init_done, 0);
    do_cmd(3'd1, 8'h08);
    check("sicw2_err", o_err, 0);
    check("sicw2_init", bus.init_done, 1);
    do_cmd(3'd2, 8'h00);
    check("sicw3_err", o_err, 1);
    check("sicw3_cs", o_cs, 0);
    do_cmd(3'd3, 8'h00);
    check("sicw4_err", o_err, 1);
    check("b2b_gap", min_gap, 2);

    // Reset in the middle of a strobe.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_data  = 8'h55;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_wr_low", bus.write_enable_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", bus.chip_select_n, 1);
    check("abort_wr_n", bus.write_enable_n, 1);
    check("abort_rd_n", bus.read_enable_n, 1);
    check("abort_oe", bus.data_bus_oe, 0);
    check("abort_rsp", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_cnt = 0;
    cs_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
      if (!bus.chip_select_n) cs_cnt++;
    end
    check("abort_no_rsp", rsp_cnt, 0);
    check("abort_no_cs", cs_cnt, 0);
    check("abort_init", bus.init_done, 0);
    do_cmd(3'd4, 8'h55);
    check("abort_ocw1_err", o_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
